wb_port_arbiter: RTL and testbench

- Shares the single register-file write port between two writeback producers: the ALU result path and the memory-load result path.
- Buffers ALU results in a small FIFO. Memory results are never buffered; memory gets priority, with an anti-starvation override for the ALU path.
- Drives the registered write port (rf_we/rf_waddr/rf_wdata) and the WB_val display value that feeds the seven-segment decoders downstream.

---
 rtl/wb_port_arbiter_if.sv | 31 +++
 rtl/wb_port_arbiter.sv | 147 ++++++++++++++
 tb/tb_wb_port_arbiter.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/wb_port_arbiter_if.sv
// Writeback port bundle: ALU and memory producer handshakes plus the
// registered register-file write port and display value.
// The producer/testbench side uses the master modport; the arbiter uses slave.
interface wb_port_arbiter_if #(
    parameter int DATA_W = 16,
    parameter int REG_W  = 3
);
    logic              alu_valid;
    logic              alu_ready;
    logic [REG_W-1:0]  alu_dest;
    logic [DATA_W-1:0] alu_data;
    logic              mem_valid;
    logic              mem_ready;
    logic [REG_W-1:0]  mem_dest;
    logic [DATA_W-1:0] mem_data;
    logic              rf_we;
    logic [REG_W-1:0]  rf_waddr;
    logic [DATA_W-1:0] rf_wdata;
    logic [DATA_W-1:0] WB_val;
    logic              stall;

    modport master (
        output alu_valid, alu_dest, alu_data, mem_valid, mem_dest, mem_data,
        input  alu_ready, mem_ready, rf_we, rf_waddr, rf_wdata, WB_val, stall
    );

    modport slave (
        input  alu_valid, alu_dest, alu_data, mem_valid, mem_dest, mem_data,
        output alu_ready, mem_ready, rf_we, rf_waddr, rf_wdata, WB_val, stall
    );
endinterface

// File: rtl/wb_port_arbiter.sv
// Writeback port arbiter: shares one register-file write port between the
// ALU result path (buffered in a small FIFO) and the memory-load path
// (unbuffered, priority). After STARVE_MAX lost arbitrations with ALU work
// pending, the FIFO head is forced through and memory is held off.
// Optional build macro WB_R0_DISCARD_EN: grants targeting register 0 are
// consumed normally but never written.
//
// state     | meaning
// MEM_PRI   | memory wins when valid, otherwise FIFO head if present
// ALU_FORCE | starvation limit hit: FIFO head granted, mem_ready held low
module wb_port_arbiter #(
    parameter int DATA_W     = 16,
    parameter int REG_W      = 3,
    parameter int FIFO_DEPTH = 2,
    parameter int STARVE_MAX = 3
) (
    input  logic             CLOCK_50,
    input  logic             RESET,
    wb_port_arbiter_if.slave bus
);
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam int STV_W = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);
    localparam logic [STV_W-1:0] STV_MAX  = STV_W'(STARVE_MAX);

    typedef enum logic [0:0] {MEM_PRI, ALU_FORCE} state_t;

    state_t             r_state, w_state_nxt;
    logic [STV_W-1:0]   r_starve_cnt, w_starve_nxt;
    logic [PTR_W-1:0]   r_head, r_tail;
    logic [CNT_W-1:0]   r_count;
    logic [REG_W-1:0]   r_fifo_dest [FIFO_DEPTH];
    logic [DATA_W-1:0]  r_fifo_data [FIFO_DEPTH];
    logic               r_rf_we;
    logic [REG_W-1:0]   r_rf_waddr;
    logic [DATA_W-1:0]  r_rf_wdata;
    logic [DATA_W-1:0]  r_wb_val;

    logic               w_full, w_empty, w_push, w_pop;
    logic               w_grant_mem, w_grant_fifo, w_write;
    logic [REG_W-1:0]   w_gnt_dest;
    logic [DATA_W-1:0]  w_gnt_data;

    assign w_full  = (r_count == FULL_CNT);
    assign w_empty = (r_count == '0);

    // Ready signals are forced low while reset is held.
    assign bus.alu_ready = !RESET && !w_full;
    assign bus.mem_ready = !RESET && w_grant_mem;
    assign bus.stall     = w_full;

    assign w_push = bus.alu_valid && bus.alu_ready;
    assign w_pop  = w_grant_fifo;

    // FIFO pointers and occupancy; pointers wrap naturally (power-of-2 depth).
    always_ff @(posedge CLOCK_50 or posedge RESET) begin
        if (RESET) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_tail <= r_tail + 1'b1;
            if (w_pop)  r_head <= r_head + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: ;
            endcase
        end
    end

    // FIFO storage; contents are don't-care until the pointers cover them.
    always_ff @(posedge CLOCK_50) begin
        if (w_push) begin
            r_fifo_dest[r_tail] <= bus.alu_dest;
            r_fifo_data[r_tail] <= bus.alu_data;
        end
    end

    // Arbitration state register and starvation counter.
    always_ff @(posedge CLOCK_50 or posedge RESET) begin
        if (RESET) begin
            r_state      <= MEM_PRI;
            r_starve_cnt <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_starve_cnt <= w_starve_nxt;
        end
    end

    // Grant selection and next-state logic.
    always_comb begin
        w_grant_mem  = 1'b0;
        w_grant_fifo = 1'b0;
        w_starve_nxt = r_starve_cnt;
        w_state_nxt  = r_state;
        case (r_state)
            ALU_FORCE: begin
                // Empty FIFO here only after an external disturbance; fall
                // back to normal priority rather than stall memory.
                if (!w_empty)           w_grant_fifo = 1'b1;
                else if (bus.mem_valid) w_grant_mem  = 1'b1;
            end
            default: begin
                if (bus.mem_valid)      w_grant_mem  = 1'b1;
                else if (!w_empty)      w_grant_fifo = 1'b1;
            end
        endcase
        if (w_empty || w_grant_fifo)
            w_starve_nxt = '0;
        else if (w_grant_mem && (r_starve_cnt < STV_MAX))
            w_starve_nxt = r_starve_cnt + 1'b1;
        w_state_nxt = (w_starve_nxt == STV_MAX) ? ALU_FORCE : MEM_PRI;
    end

    assign w_gnt_dest = w_grant_fifo ? r_fifo_dest[r_head] : bus.mem_dest;
    assign w_gnt_data = w_grant_fifo ? r_fifo_data[r_head] : bus.mem_data;

`ifdef WB_R0_DISCARD_EN
    assign w_write = (w_grant_mem || w_grant_fifo) && (w_gnt_dest != '0);
`else
    assign w_write = w_grant_mem || w_grant_fifo;
`endif

    // One-cycle registered write port; address/data hold when idle.
    always_ff @(posedge CLOCK_50 or posedge RESET) begin
        if (RESET) begin
            r_rf_we    <= 1'b0;
            r_rf_waddr <= '0;
            r_rf_wdata <= '0;
            r_wb_val   <= '0;
        end else begin
            r_rf_we <= w_write;
            if (w_write) begin
                r_rf_waddr <= w_gnt_dest;
                r_rf_wdata <= w_gnt_data;
                r_wb_val   <= w_gnt_data;
            end
        end
    end

    assign bus.rf_we    = r_rf_we;
    assign bus.rf_waddr = r_rf_waddr;
    assign bus.rf_wdata = r_rf_wdata;
    assign bus.WB_val   = r_wb_val;
endmodule

// File: tb/tb_wb_port_arbiter.sv
// Self-checking bench for wb_port_arbiter: directed scenarios plus a
// randomized run, all checked against a queue-based behavioural model.
module tb_wb_port_arbiter;
    localparam int DEPTH = 2;
    localparam int SMAX  = 3;

    typedef struct {
        logic [2:0]  dest;
        logic [15:0] data;
    } ent_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    wb_port_arbiter_if #(.DATA_W(16), .REG_W(3)) bus ();

    wb_port_arbiter #(.DATA_W(16), .REG_W(3), .FIFO_DEPTH(DEPTH), .STARVE_MAX(SMAX)) dut (
        .CLOCK_50 (clk),
        .RESET    (rst),
        .bus      (bus.slave)
    );

    int n_cmp = 0;
    int n_err = 0;

    // reference model state
    ent_t        q[$];
    int          m_lost;
    logic        exp_we;
    logic [2:0]  exp_waddr;
    logic [15:0] exp_wdata, exp_wb;
    logic        exp_alu_ready, exp_mem_ready, exp_stall;
    logic        g_mem, g_fifo, g_push, m_nonempty;
    logic [2:0]  c_ad, c_md;
    logic [15:0] c_adat, c_mdat;

    task automatic model_reset();
        q.delete();
        m_lost    = 0;
        exp_we    = 1'b0;
        exp_waddr = '0;
        exp_wdata = '0;
        exp_wb    = '0;
    endtask

    // Drive one cycle's inputs, then evaluate the model's decision for it.
    task automatic apply(input logic av, input logic [2:0] ad, input logic [15:0] adat,
                         input logic mv, input logic [2:0] md, input logic [15:0] mdat);
        logic force_alu;
        bus.alu_valid = av;  bus.alu_dest = ad;  bus.alu_data = adat;
        bus.mem_valid = mv;  bus.mem_dest = md;  bus.mem_data = mdat;
        c_ad = ad; c_adat = adat; c_md = md; c_mdat = mdat;
        @(negedge clk);
        m_nonempty    = (q.size() > 0);
        exp_alu_ready = !rst && (q.size() < DEPTH);
        exp_stall     = (q.size() == DEPTH);
        force_alu     = m_nonempty && (m_lost == SMAX);
        g_mem         = mv && !force_alu;
        g_fifo        = m_nonempty && !g_mem;
        exp_mem_ready = g_mem && !rst;
        g_push        = av && exp_alu_ready;
    endtask

    // Take the clock edge and advance the model's registered expectations.
    task automatic advance();
        ent_t       e;
        logic [2:0] wd;
        logic [15:0] wdat;
        logic       wr;
        @(posedge clk);
        #1;
        wd = c_md; wdat = c_mdat;
        if (g_fifo) begin
            e = q.pop_front();
            wd = e.dest; wdat = e.data;
        end
        if (!m_nonempty || g_fifo) m_lost = 0;
        else if (g_mem && m_lost < SMAX) m_lost = m_lost + 1;
        if (g_push) q.push_back('{dest: c_ad, data: c_adat});
`ifdef WB_R0_DISCARD_EN
        wr = (g_mem || g_fifo) && (wd != 3'd0);
`else
        wr = g_mem || g_fifo;
`endif
        exp_we = wr;
        if (wr) begin
            exp_waddr = wd;
            exp_wdata = wdat;
            exp_wb    = wdat;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.alu_valid = 1'b1; bus.alu_dest = 3'd1; bus.alu_data = 16'h1111;
        bus.mem_valid = 1'b1; bus.mem_dest = 3'd1; bus.mem_data = 16'h2222;
        model_reset();
        repeat (2) @(negedge clk);
        n_cmp++; if (bus.alu_ready !== 1'b0) begin n_err++; $display("FAIL rst_alu_ready got=%b exp=0", bus.alu_ready); end
        n_cmp++; if (bus.mem_ready !== 1'b0) begin n_err++; $display("FAIL rst_mem_ready got=%b exp=0", bus.mem_ready); end
        n_cmp++; if (bus.rf_we !== 1'b0) begin n_err++; $display("FAIL rst_rf_we got=%b exp=0", bus.rf_we); end
        bus.alu_valid = 1'b0; bus.mem_valid = 1'b0;
        rst = 1'b0;
        apply(0, 0, 0, 0, 0, 0);
        n_cmp++; if (bus.alu_ready !== exp_alu_ready) begin n_err++; $display("FAIL idle_alu_ready got=%b exp=%b", bus.alu_ready, exp_alu_ready); end
        n_cmp++; if (bus.mem_ready !== exp_mem_ready) begin n_err++; $display("FAIL idle_mem_ready got=%b exp=%b", bus.mem_ready, exp_mem_ready); end
        n_cmp++; if (bus.stall !== exp_stall) begin n_err++; $display("FAIL idle_stall got=%b exp=%b", bus.stall, exp_stall); end
        advance();
        n_cmp++; if (bus.rf_we !== exp_we) begin n_err++; $display("FAIL idle_rf_we got=%b exp=%b", bus.rf_we, exp_we); end
        n_cmp++; if (bus.WB_val !== 16'h0000) begin n_err++; $display("FAIL idle_wb_val got=%h exp=0000", bus.WB_val); end
    endtask

    task automatic test_mem_single();
        apply(0, 0, 0, 1, 3'd5, 16'hBEEF);
        n_cmp++; if (bus.mem_ready !== exp_mem_ready) begin n_err++; $display("FAIL mem1_ready got=%b exp=%b", bus.mem_ready, exp_mem_ready); end
        advance();
        n_cmp++; if (bus.rf_we !== exp_we) begin n_err++; $display("FAIL mem1_we got=%b exp=%b", bus.rf_we, exp_we); end
        n_cmp++; if (bus.rf_waddr !== exp_waddr) begin n_err++; $display("FAIL mem1_waddr got=%0d exp=%0d", bus.rf_waddr, exp_waddr); end
        n_cmp++; if (bus.rf_wdata !== 16'hBEEF) begin n_err++; $display("FAIL mem1_wdata got=%h exp=beef", bus.rf_wdata); end
        n_cmp++; if (bus.WB_val !== exp_wb) begin n_err++; $display("FAIL mem1_wb_val got=%h exp=%h", bus.WB_val, exp_wb); end
        apply(0, 0, 0, 0, 0, 0);
        advance();
        n_cmp++; if (bus.rf_we !== exp_we) begin n_err++; $display("FAIL mem1_idle_we got=%b exp=%b", bus.rf_we, exp_we); end
    endtask

    task automatic test_starvation();
        apply(1, 3'd2, 16'h1234, 0, 0, 0);
        advance();
        for (int i = 0; i < 6; i++) begin
            apply(0, 0, 0, 1, 3'(3 + (i % 4)), 16'hA000 + 16'(i));
            n_cmp++; if (bus.mem_ready !== exp_mem_ready) begin n_err++; $display("FAIL starve_mem_ready[%0d] got=%b exp=%b", i, bus.mem_ready, exp_mem_ready); end
            if (i == 3) begin
                n_cmp++; if (bus.mem_ready !== 1'b0) begin n_err++; $display("FAIL starve_forced_cycle got=%b exp=0", bus.mem_ready); end
            end
            advance();
            n_cmp++; if (bus.rf_wdata !== exp_wdata || bus.rf_waddr !== exp_waddr || bus.rf_we !== exp_we) begin
                n_err++; $display("FAIL starve_write[%0d] got=%b/%0d/%h exp=%b/%0d/%h", i, bus.rf_we, bus.rf_waddr, bus.rf_wdata, exp_we, exp_waddr, exp_wdata);
            end
            if (i == 3) begin
                n_cmp++; if (bus.rf_we !== 1'b1 || bus.rf_waddr !== 3'd2 || bus.rf_wdata !== 16'h1234) begin
                    n_err++; $display("FAIL starve_alu_write got=%b/%0d/%h exp=1/2/1234", bus.rf_we, bus.rf_waddr, bus.rf_wdata);
                end
            end
        end
        apply(0, 0, 0, 0, 0, 0);
        advance();
    endtask

    task automatic test_back_to_back();
        apply(1, 3'd6, 16'h0A0A, 1, 3'd1, 16'h5555);
        advance();
        apply(1, 3'd7, 16'h0B0B, 1, 3'd1, 16'h6666);
        advance();
        apply(1, 3'd4, 16'h0C0C, 0, 0, 0);
        n_cmp++; if (bus.stall !== 1'b1) begin n_err++; $display("FAIL b2b_stall_full got=%b exp=1", bus.stall); end
        n_cmp++; if (bus.alu_ready !== exp_alu_ready) begin n_err++; $display("FAIL b2b_alu_ready got=%b exp=%b", bus.alu_ready, exp_alu_ready); end
        advance();
        n_cmp++; if (bus.rf_we !== 1'b1 || bus.rf_wdata !== 16'h0A0A) begin n_err++; $display("FAIL b2b_first got=%b/%h exp=1/0a0a", bus.rf_we, bus.rf_wdata); end
        apply(0, 0, 0, 0, 0, 0);
        n_cmp++; if (bus.stall !== exp_stall) begin n_err++; $display("FAIL b2b_stall_drain got=%b exp=%b", bus.stall, exp_stall); end
        advance();
        n_cmp++; if (bus.rf_we !== 1'b1 || bus.rf_wdata !== 16'h0B0B) begin n_err++; $display("FAIL b2b_second got=%b/%h exp=1/0b0b", bus.rf_we, bus.rf_wdata); end
        apply(0, 0, 0, 0, 0, 0);
        n_cmp++; if (bus.stall !== 1'b0) begin n_err++; $display("FAIL b2b_stall_clear got=%b exp=0", bus.stall); end
        advance();
        n_cmp++; if (bus.rf_we !== exp_we) begin n_err++; $display("FAIL b2b_idle_we got=%b exp=%b", bus.rf_we, exp_we); end
    endtask

    task automatic test_reset_mid();
        apply(1, 3'd3, 16'h7777, 1, 3'd5, 16'h8888);
        advance();
        apply(1, 3'd4, 16'h9999, 1, 3'd5, 16'hAAAA);
        advance();
        apply(0, 0, 0, 1, 3'd6, 16'hBBBB);
        #2 rst = 1'b1;
        #1;
        n_cmp++; if (bus.rf_we !== 1'b0 || bus.rf_waddr !== 3'd0 || bus.rf_wdata !== 16'h0) begin
            n_err++; $display("FAIL rstmid_port got=%b/%0d/%h exp=0/0/0000", bus.rf_we, bus.rf_waddr, bus.rf_wdata);
        end
        n_cmp++; if (bus.WB_val !== 16'h0) begin n_err++; $display("FAIL rstmid_wb_val got=%h exp=0000", bus.WB_val); end
        n_cmp++; if (bus.alu_ready !== 1'b0 || bus.mem_ready !== 1'b0 || bus.stall !== 1'b0) begin
            n_err++; $display("FAIL rstmid_ctrl got=%b/%b/%b exp=0/0/0", bus.alu_ready, bus.mem_ready, bus.stall);
        end
        bus.mem_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        for (int i = 0; i < 3; i++) begin
            apply(0, 0, 0, 0, 0, 0);
            n_cmp++; if (bus.alu_ready !== exp_alu_ready || bus.stall !== exp_stall) begin
                n_err++; $display("FAIL rstmid_after_ctrl[%0d] got=%b/%b exp=%b/%b", i, bus.alu_ready, bus.stall, exp_alu_ready, exp_stall);
            end
            advance();
            n_cmp++; if (bus.rf_we !== 1'b0) begin n_err++; $display("FAIL rstmid_stale_write[%0d] got=%b exp=0", i, bus.rf_we); end
        end
    endtask

    task automatic test_dest_zero();
        apply(0, 0, 0, 1, 3'd3, 16'h4321);
        advance();
        apply(0, 0, 0, 1, 3'd0, 16'hFFFF);
        n_cmp++; if (bus.mem_ready !== 1'b1) begin n_err++; $display("FAIL r0_mem_ready got=%b exp=1", bus.mem_ready); end
        advance();
        n_cmp++; if (bus.rf_we !== exp_we) begin n_err++; $display("FAIL r0_we got=%b exp=%b", bus.rf_we, exp_we); end
        n_cmp++; if (bus.WB_val !== exp_wb) begin n_err++; $display("FAIL r0_wb_val got=%h exp=%h", bus.WB_val, exp_wb); end
`ifdef WB_R0_DISCARD_EN
        n_cmp++; if (bus.rf_we !== 1'b0 || bus.WB_val !== 16'h4321) begin
            n_err++; $display("FAIL r0_discard got=%b/%h exp=0/4321", bus.rf_we, bus.WB_val);
        end
`endif
        apply(0, 0, 0, 0, 0, 0);
        advance();
    endtask

    task automatic test_random();
        logic av, mv;
        for (int i = 0; i < 400; i++) begin
            av = ($urandom_range(0, 99) < 55);
            mv = ($urandom_range(0, 99) < 60);
            apply(av, 3'($urandom_range(0, 7)), 16'($urandom), mv, 3'($urandom_range(0, 7)), 16'($urandom));
            n_cmp++; if (bus.alu_ready !== exp_alu_ready || bus.mem_ready !== exp_mem_ready || bus.stall !== exp_stall) begin
                n_err++; $display("FAIL rnd_ctrl[%0d] got=%b/%b/%b exp=%b/%b/%b", i, bus.alu_ready, bus.mem_ready, bus.stall, exp_alu_ready, exp_mem_ready, exp_stall);
            end
            advance();
            n_cmp++; if (bus.rf_we !== exp_we || bus.rf_waddr !== exp_waddr || bus.rf_wdata !== exp_wdata || bus.WB_val !== exp_wb) begin
                n_err++; $display("FAIL rnd_write[%0d] got=%b/%0d/%h/%h exp=%b/%0d/%h/%h", i, bus.rf_we, bus.rf_waddr, bus.rf_wdata, bus.WB_val, exp_we, exp_waddr, exp_wdata, exp_wb);
            end
        end
    endtask

    initial begin
        bus.alu_valid = 1'b0; bus.alu_dest = '0; bus.alu_data = '0;
        bus.mem_valid = 1'b0; bus.mem_dest = '0; bus.mem_data = '0;
        test_reset();
        test_mem_single();
        test_starvation();
        test_back_to_back();
        test_reset_mid();
        test_dest_zero();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
